// File: rtl/rf_wport_sched.sv
// rf_wport_sched: merges WB and long-latency results onto one RF write port, with a pending-destination hazard scoreboard.
// Optional RF_WPORT_STATS_EN adds starve_cnt and max_occ statistics outputs.
module rf_wport_sched #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_waddr,
    input  logic [DATA_W-1:0] lu_wdata,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_waddr,
    input  logic              id_re1,
    input  logic [ADDR_W-1:0] id_raddr1,
    input  logic              id_re2,
    input  logic [ADDR_W-1:0] id_raddr2,
    input  logic              id_we,
    input  logic [ADDR_W-1:0] id_waddr,
    output logic              hazard_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
`ifdef RF_WPORT_STATS_EN
    output logic [15:0]                   starve_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   max_occ,
`endif
    output logic [ADDR_W:0]   pending_cnt
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int NREG = 1 << ADDR_W;

    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [PW:0]       count;
    logic [NREG-1:0]   pending, busy;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              empty, push, drain, clr, set, inc, dec;

    always_comb begin
        head_addr    = addr_mem[rd_ptr];
        head_data    = data_mem[rd_ptr];
        empty        = count == '0;
        lu_ready     = !rst && (count < (PW+1)'(FIFO_DEPTH));
        push         = lu_valid && lu_ready;
        drain        = !rst && !wb_we && !empty;
        clr          = drain && head_addr != '0;
        rf_we        = !rst && (wb_we || clr);
        rf_waddr     = rst ? '0 : wb_we ? wb_waddr : drain ? head_addr : '0;
        rf_wdata     = rst ? '0 : wb_we ? wb_wdata : drain ? head_data : '0;
        // a register drained this cycle is forwarded by the RF bypass, so it is not busy
        busy         = pending & ~(NREG'(clr) << head_addr);
        hazard_stall = !rst && ((id_re1 && busy[id_raddr1]) || (id_re2 && busy[id_raddr2]) ||
                                (id_we && busy[id_waddr]) || (issue_valid && busy[issue_waddr]));
        set          = issue_valid && !hazard_stall && issue_waddr != '0;
        inc          = set && !pending[issue_waddr];
        dec          = clr && pending[head_addr] && !(set && issue_waddr == head_addr);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= lu_waddr;
            data_mem[wr_ptr] <= lu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (drain) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(drain);
            if (clr) pending[head_addr] <= 1'b0;
            if (set) pending[issue_waddr] <= 1'b1;
            pending_cnt <= pending_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
        end
    end

`ifdef RF_WPORT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            max_occ    <= '0;
        end else begin
            if (!empty && wb_we && starve_cnt != '1) starve_cnt <= starve_cnt + 1'b1;
            if (count > max_occ) max_occ <= count;
        end
    end
`endif
endmodule

// File: tb/tb_rf_wport_sched.sv
// tb_rf_wport_sched: directed plan steps plus random traffic checked against a queue/array reference model.
module tb_rf_wport_sched;
    localparam int DW = 32, AW = 5, DEPTH = 2;

    logic clk = 0, rst = 1;
    logic wb_we = 0, lu_valid = 0, issue_valid = 0, id_re1 = 0, id_re2 = 0, id_we = 0;
    logic [AW-1:0] wb_waddr = 0, lu_waddr = 0, issue_waddr = 0, id_raddr1 = 0, id_raddr2 = 0, id_waddr = 0;
    logic [DW-1:0] wb_wdata = 0, lu_wdata = 0;
    logic lu_ready, hazard_stall, rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW:0]   pending_cnt;

    int checks = 0, failures = 0;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
    ent_t q[$];
    bit   pend[32];

    rf_wport_sched #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .issue_valid(issue_valid), .issue_waddr(issue_waddr),
        .id_re1(id_re1), .id_raddr1(id_raddr1), .id_re2(id_re2), .id_raddr2(id_raddr2),
        .id_we(id_we), .id_waddr(id_waddr), .hazard_stall(hazard_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hz(input bit en, input logic [AW-1:0] a, input bit drn, input logic [AW-1:0] ha);
        return en && a != 0 && pend[a] && !(drn && ha == a);
    endfunction

    // Called just after a negedge with inputs set; checks, then advances the model over the posedge.
    task automatic cycle(input bit chk_cnt = 1);
        bit drn, stall, e_we, e_rdy;
        logic [AW-1:0] ha, e_a;
        logic [DW-1:0] e_d;
        int n;
        #1;
        drn   = !rst && !wb_we && q.size() > 0;
        ha    = q.size() > 0 ? q[0].a : '0;
        e_rdy = !rst && q.size() < DEPTH;
        stall = !rst && (hz(id_re1, id_raddr1, drn, ha) || hz(id_re2, id_raddr2, drn, ha) ||
                         hz(id_we, id_waddr, drn, ha) || hz(issue_valid, issue_waddr, drn, ha));
        e_we  = !rst && (wb_we || (drn && ha != 0));
        e_a   = rst ? '0 : wb_we ? wb_waddr : drn ? ha : '0;
        e_d   = rst ? '0 : wb_we ? wb_wdata : drn ? q[0].d : '0;
        check("lu_ready", lu_ready, e_rdy);
        check("hazard_stall", hazard_stall, stall);
        check("rf_we", rf_we, e_we);
        if (e_we || rst) begin
            check("rf_waddr", rf_waddr, e_a);
            check("rf_wdata", rf_wdata, e_d);
        end
        if (chk_cnt) begin
            n = 0;
            foreach (pend[i]) n += pend[i];
            check("pending_cnt", pending_cnt, n);
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            foreach (pend[i]) pend[i] = 0;
        end else begin
            if (drn) begin
                if (ha != 0) pend[ha] = 0;
                void'(q.pop_front());
            end
            if (lu_valid && e_rdy) q.push_back('{lu_waddr, lu_wdata});
            if (issue_valid && !stall && issue_waddr != 0) pend[issue_waddr] = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        wb_we = 0; lu_valid = 0; issue_valid = 0; id_re1 = 0; id_re2 = 0; id_we = 0;
    endtask

    initial begin
        @(negedge clk);
        rst = 1; cycle(0);
        rst = 0; idle(); cycle();
        // plan 1: WB write passes straight through
        wb_we = 1; wb_waddr = 5; wb_wdata = 32'h1234; cycle();
        // plan 2: long-latency op to r8, read stalls until drain
        idle(); issue_valid = 1; issue_waddr = 8; cycle();
        idle(); id_re1 = 1; id_raddr1 = 8; cycle();
        lu_valid = 1; lu_waddr = 8; lu_wdata = 32'hCAFE; cycle();
        lu_valid = 0; cycle();
        cycle();
        // plan 3: fill FIFO under WB pressure, then drain in order
        idle(); wb_we = 1; wb_waddr = 1; wb_wdata = 32'h11;
        lu_valid = 1; lu_waddr = 9; lu_wdata = 32'hA; cycle();
        lu_waddr = 10; lu_wdata = 32'hB; cycle();
        lu_valid = 0; cycle(); cycle();
        wb_we = 0; cycle(); cycle(); cycle();
        // plan 4: drain of r3 coincides with a new issue to r3
        issue_valid = 1; issue_waddr = 3; cycle();
        issue_valid = 0; wb_we = 1; lu_valid = 1; lu_waddr = 3; lu_wdata = 32'h33; cycle();
        lu_valid = 0; wb_we = 0; issue_valid = 1; issue_waddr = 3; cycle();
        idle(); id_re2 = 1; id_raddr2 = 3; cycle();
        lu_valid = 1; lu_waddr = 3; lu_wdata = 32'h34; cycle();
        idle(); cycle();
        // plan 5: register 0 never tracked nor written
        issue_valid = 1; issue_waddr = 0; cycle();
        idle(); lu_valid = 1; lu_waddr = 0; lu_wdata = 32'h77; id_re1 = 1; id_raddr1 = 0; cycle();
        idle(); cycle();
        // plan 6: reset with full FIFO and pending bits
        issue_valid = 1; issue_waddr = 12; cycle();
        issue_waddr = 13; wb_we = 1; lu_valid = 1; lu_waddr = 20; lu_wdata = 1; cycle();
        issue_valid = 0; lu_waddr = 21; lu_wdata = 2; cycle();
        idle(); rst = 1; cycle();
        rst = 0; cycle(); cycle();
        // random traffic over a narrow address range to provoke hazards
        for (int k = 0; k < 3000; k++) begin
            rst         = ($urandom_range(0, 199) == 0);
            wb_we       = $urandom_range(0, 1);
            wb_waddr    = $urandom_range(0, 7);
            wb_wdata    = $urandom;
            lu_valid    = $urandom_range(0, 2) == 0;
            lu_waddr    = $urandom_range(0, 7);
            lu_wdata    = $urandom;
            issue_valid = $urandom_range(0, 3) == 0;
            issue_waddr = $urandom_range(0, 7);
            id_re1      = $urandom_range(0, 1);
            id_raddr1   = $urandom_range(0, 7);
            id_re2      = $urandom_range(0, 1);
            id_raddr2   = $urandom_range(0, 7);
            id_we       = $urandom_range(0, 1);
            id_waddr    = $urandom_range(0, 7);
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_wport_sched.md
Name: rf_wport_sched

Overview:
- Scheduler for the register file's single write port.
- Merges two writers onto one write port:
  - the in-order pipeline WB stage, which is never back-pressured;
  - a long-latency unit (divider / load-miss return), valid/ready handshake.
- LU results queue in a small FIFO and drain on idle WB cycles.
- A pending-destination scoreboard generates the ID-stage stall for RAW/WAW hazards on registers with an outstanding long-latency write.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width; register 0 is hardwired zero.
- FIFO_DEPTH, 2, LU result buffer entries; power of two, >=2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wb_we  in  1  WB stage write request.
- wb_waddr  in  ADDR_W  WB destination.
- wb_wdata  in  DATA_W  WB data.
- lu_valid  in  1  LU result valid.
- lu_ready  out  1  FIFO can accept.
- lu_waddr  in  ADDR_W  LU destination.
- lu_wdata  in  DATA_W  LU data.
- issue_valid  in  1  ID dispatches a long-latency op this cycle.
- issue_waddr  in  ADDR_W  its destination.
- id_re1  in  1  ID read enable, port 1.
- id_raddr1  in  ADDR_W  ID read address, port 1.
- id_re2  in  1  ID read enable, port 2.
- id_raddr2  in  ADDR_W  ID read address, port 2.
- id_we  in  1  ID instruction writes a register.
- id_waddr  in  ADDR_W  its destination.
- hazard_stall  out  1  ID must hold.
- rf_we  out  1  register file write enable.
- rf_waddr  out  ADDR_W  register file write address.
- rf_wdata  out  DATA_W  register file write data.
- pending_cnt  out  ADDR_W+1  number of outstanding long-latency destinations.

Behaviour:
- Reset:
  - Synchronous, clk and rst already decided.
  - FIFO empty, scoreboard cleared, pending_cnt=0.
  - lu_ready=0, hazard_stall=0, rf_we=0, rf_waddr=0, rf_wdata=0 while rst=1.
  - A reset mid-operation discards all buffered results and pending bits.
- Write-port mux (combinational, zero latency):
  - If wb_we=1: rf_* = wb_*.
  - Else if FIFO is non-empty: rf_* = FIFO head, and the head pops at the clk edge (drain).
  - Otherwise rf_we=0.
  - WB always wins the port.
- FIFO:
  - lu_ready = (count < FIFO_DEPTH) && !rst. It is deasserted when full, even if a pop occurs in the same cycle; there is no pass-through.
  - Push on lu_valid && lu_ready. Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - An entry with waddr=0 is still accepted and popped, but is driven with rf_we=0.
- Scoreboard: pending[1..2^ADDR_W-1].
  - Set on issue_valid && issue_waddr!=0.
  - Clear on drain of an entry with that waddr.
  - Set and clear of the same register in the same cycle: set wins.
  - pending_cnt tracks the number of set bits.
- hazard_stall (combinational). Asserted if any of these hits a register that is pending and not being cleared this cycle:
  - id_re1 && id_raddr1;
  - id_re2 && id_raddr2;
  - id_we && id_waddr;
  - issue_valid && issue_waddr.
- A register being drained this cycle is not a hazard; the register file's same-cycle bypass forwards the data.
- Address 0 never causes a stall.
- When hazard_stall=1, ID must not assert issue_valid for a new op. issue_valid while hazard_stall=1 is ignored (no set).

Optional Feature:
- Macro: RF_WPORT_STATS_EN.
- When defined:
  - Adds output starve_cnt[15:0], a saturating count of cycles where the FIFO is non-empty and wb_we=1 (drain blocked).
  - Adds output max_occ[$clog2(FIFO_DEPTH):0], the high-water mark of FIFO count.
  - Both reset to 0.
- When undefined: ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
1. Idle LU; wb_we=1, waddr=5, wdata=0x1234 -> same cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; lu_ready=1.
2. issue_valid waddr=8; next cycle id_re1=1, raddr1=8 -> hazard_stall=1. LU returns (8, 0xCAFE) with wb_we=0 -> rf write 8/0xCAFE; hazard_stall=0 in that drain cycle; pending_cnt 1->0.
3. Two LU results pushed while wb_we=1 for 4 cycles -> FIFO full, lu_ready=0, no rf write from FIFO. wb_we drops -> two consecutive drains in push order, then lu_ready=1.
4. Drain of reg 3 and issue_valid to reg 3 in the same cycle -> pending[3] remains 1, and pending_cnt is unchanged.
5. issue_valid waddr=0, and LU result waddr=0 -> no pending set, no stall, rf_we=0 on drain.
6. rst asserted with 2 FIFO entries and 2 pending -> next cycle lu_ready=1, pending_cnt=0, no rf writes. With RF_WPORT_STATS_EN, starve_cnt=0 and max_occ=0.
